// File: rtl/uart_mon_pkg.sv
// UART RX monitor shared types.
// FSM states, parity modes and parity helper.
package uart_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HI
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Expected parity bit for a data byte in the given mode.
  function automatic logic parity_bit(
    input logic [7:0] data,
    input logic [1:0] mode
  );
    parity_bit = (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Receive FIFO for the UART monitor.
// Push is dropped when full unless a pop frees a slot.
module uart_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rp];
  assign o_level   = r_level;

  // Storage array; written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver/monitor: sync, oversampled bit decode,
// frame FSM, error pulses and a receive FIFO.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               rx,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun,
  output logic               break_det
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] C_TICK  = CW'(CLK_PER_BIT/2 + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    DB_LAST = 3'(DATA_BITS - 1);
  localparam logic          SB_LAST = 1'(STOP_BITS - 1);
  localparam logic [1:0]    MODE    = 2'(PARITY);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_sync;
  logic [1:0]             r_hist;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bidx;
  logic                   r_sidx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic                   r_stop_low;
  logic                   r_fe;
  logic                   r_pe;
  logic                   r_ov;
  logic                   r_bk;
  logic                   w_rx;
  logic                   w_fall;
  logic                   w_tick;
  logic                   w_samp;
  logic                   w_stop_low;
  logic [7:0]             w_byte;
  logic                   w_push;
  logic                   w_fe;
  logic                   w_pe;
  logic                   w_bk;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  assign w_rx   = r_sync[1];
  assign w_fall = (r_state == IDLE) & r_hist[0] & ~w_rx;
  assign w_tick = (r_cnt == C_TICK);
  assign w_samp = (w_rx & r_hist[0]) | (w_rx & r_hist[1])
                | (r_hist[0] & r_hist[1]);
  assign w_stop_low = r_stop_low | ~w_samp;
  assign w_byte = 8'(r_shift);

  // Two-flop synchroniser plus the two older majority taps.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync <= 2'b11;
      r_hist <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_hist <= {r_hist[0], w_rx};
    end
  end

  // Bit-phase counter; phase 0 is the first low sample.
  always_ff @(posedge HCLK) begin
    if (HRESET)                 r_cnt <= '0;
    else if (w_fall)            r_cnt <= CW'(1);
    else if (r_state == IDLE ||
             r_state == WAIT_HI) r_cnt <= '0;
    else if (r_cnt == C_LAST)   r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, frame commit and error decisions.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_fe   = 1'b0;
    w_pe   = 1'b0;
    w_bk   = 1'b0;
    unique case (r_state)
      IDLE:  if (w_fall) w_next = START;
      START: if (w_tick) w_next = w_samp ? IDLE : DATA;
      DATA:
        if (w_tick && r_bidx == DB_LAST)
          w_next = (MODE != PAR_NONE) ? PAR : STOP;
      PAR:   if (w_tick) w_next = STOP;
      STOP:
        if (w_tick && r_sidx == SB_LAST) begin
          if (w_stop_low) begin
            w_next = WAIT_HI;
            if (r_shift == '0) begin
              w_bk = 1'b1;
            end else begin
              w_fe   = 1'b1;
              w_push = 1'b1;
            end
          end else begin
            w_next = IDLE;
            w_push = 1'b1;
            w_pe   = r_par_err;
          end
        end
      WAIT_HI: if (w_rx) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame datapath: data shift, parity and stop tracking.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_bidx     <= '0;
      r_sidx     <= 1'b0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stop_low <= 1'b0;
    end else begin
      if (w_fall) begin
        r_bidx     <= '0;
        r_sidx     <= 1'b0;
        r_par_err  <= 1'b0;
        r_stop_low <= 1'b0;
      end
      if (w_tick && r_state == DATA) begin
        r_shift <= {w_samp, r_shift[DATA_BITS-1:1]};
        r_bidx  <= r_bidx + 1'b1;
      end
      if (w_tick && r_state == PAR)
        r_par_err <= (w_samp != parity_bit(w_byte, MODE));
      if (w_tick && r_state == STOP) begin
        r_stop_low <= w_stop_low;
        r_sidx     <= r_sidx + 1'b1;
      end
    end
  end

  // Registered one-cycle event pulses.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_fe <= 1'b0;
      r_pe <= 1'b0;
      r_ov <= 1'b0;
      r_bk <= 1'b0;
    end else begin
      r_fe <= w_fe;
      r_pe <= w_pe;
      r_ov <= w_push & w_full & ~w_pop;
      r_bk <= w_bk;
    end
  end

  assign rd_valid   = ~w_empty;
  assign w_pop      = rd_valid & rd_ready;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ov;
  assign break_det  = r_bk;

  uart_mon_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_push  (w_push),
    .i_wdata (w_byte),
    .i_pop   (w_pop),
    .o_rdata (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: an 8N1 and an 8E1 instance
// driven by a serial bit driver and checked against queues.
module tb_uart_rx_monitor;

  localparam int CPB = 16;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       rx_a, rx_b;
  logic       rdy_a, rdy_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic [3:0] lvl_a, lvl_b;
  logic       fe_a, pe_a, ov_a, bk_a;
  logic       fe_b, pe_b, ov_b, bk_b;

  int tests = 0;
  int fails = 0;

  int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_bk_a = 0;
  int n_fe_b = 0, n_pe_b = 0, n_ov_b = 0, n_bk_b = 0;
  int n_got_a = 0, n_got_b = 0;
  logic [7:0] got_a [64];
  logic [7:0] got_b [64];

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int chk_a = 0, chk_b = 0;

  always #5 HCLK = ~HCLK;

  uart_rx_monitor #(
    .CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(8), .FIFO_AW(3)
  ) u_a (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .rd_ready(rdy_a), .fifo_level(lvl_a),
    .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ov_a), .break_det(bk_a)
  );

  uart_rx_monitor #(
    .CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(8), .FIFO_AW(3)
  ) u_b (
    .HCLK(HCLK), .HRESET(HRESET), .rx(rx_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_ready(rdy_b), .fifo_level(lvl_b),
    .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ov_b), .break_det(bk_b)
  );

  // Mid-cycle monitor: pulse counts and popped bytes.
  always @(negedge HCLK) begin
    if (fe_a) n_fe_a <= n_fe_a + 1;
    if (pe_a) n_pe_a <= n_pe_a + 1;
    if (ov_a) n_ov_a <= n_ov_a + 1;
    if (bk_a) n_bk_a <= n_bk_a + 1;
    if (fe_b) n_fe_b <= n_fe_b + 1;
    if (pe_b) n_pe_b <= n_pe_b + 1;
    if (ov_b) n_ov_b <= n_ov_b + 1;
    if (bk_b) n_bk_b <= n_bk_b + 1;
    if (rd_valid_a && rdy_a) begin
      got_a[n_got_a] <= rd_data_a;
      n_got_a <= n_got_a + 1;
    end
    if (rd_valid_b && rdy_b) begin
      got_b[n_got_b] <= rd_data_b;
      n_got_b <= n_got_b + 1;
    end
  end

  task automatic check(input string tag, input int obs,
                       input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic bit_out(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
    tick(CPB);
  endtask

  // Serial frame: start, 8 data LSB first, optional parity, stop.
  task automatic send_frame(input int d, input logic [7:0] data,
                            input int pmode, input logic bad_par,
                            input logic stop_v);
    int ones;
    logic p;
    bit_out(d, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(d, data[i]);
    if (pmode != 0) begin
      ones = $countones(data);
      if (pmode == 2) p = (ones % 2 == 1);
      else            p = (ones % 2 == 0);
      if (bad_par) p = ~p;
      bit_out(d, p);
    end
    bit_out(d, stop_v);
  endtask

  task automatic check_stream(input string tag, input int d);
    if (d == 0) begin
      check({tag, "_cnt"}, n_got_a, exp_a.size());
      for (int k = chk_a; k < exp_a.size(); k++)
        check($sformatf("%s_a%0d", tag, k), got_a[k], exp_a[k]);
      chk_a = exp_a.size();
    end else begin
      check({tag, "_cnt"}, n_got_b, exp_b.size());
      for (int k = chk_b; k < exp_b.size(); k++)
        check($sformatf("%s_b%0d", tag, k), got_b[k], exp_b[k]);
      chk_b = exp_b.size();
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] vec [3];
    logic bad;
    int exp_pe_b;
    int s_fe, s_bk, s_ov;

    rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0;
    HRESET = 1'b1;
    tick(4);
    check("rst_valid_a", rd_valid_a, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_level_a", lvl_a, 0);
    check("rst_valid_b", rd_valid_b, 0);
    check("rst_pulses", {fe_a, pe_a, ov_a, bk_a}, 0);
    HRESET = 1'b0;
    tick(4);

    // Plain 8N1 bytes, popped immediately.
    rdy_a = 1'b1;
    vec[0] = 8'h55; vec[1] = 8'hA3; vec[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      send_frame(0, vec[i], 0, 1'b0, 1'b1);
      exp_a.push_back(vec[i]);
    end
    tick(4);
    check_stream("basic", 0);
    check("basic_err",
          n_fe_a + n_pe_a + n_ov_a + n_bk_a, 0);

    // Even parity, wrong parity bit: stored, flagged.
    send_frame(1, 8'h07, 2, 1'b1, 1'b1);
    tick(4);
    check("par_level", lvl_b, 1);
    check("par_data", rd_data_b, 8'h07);
    check("par_err", n_pe_b, 1);
    exp_b.push_back(8'h07);
    rdy_b = 1'b1;
    exp_pe_b = 1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bad = 1'($urandom);
      send_frame(1, b, 2, bad, 1'b1);
      exp_b.push_back(b);
      if (bad) exp_pe_b++;
    end
    tick(4);
    check_stream("par_rand", 1);
    check("par_rand_pe", n_pe_b, exp_pe_b);
    check("par_rand_fe", n_fe_b + n_bk_b + n_ov_b, 0);

    // Low stop bit, line held low, then a clean byte.
    s_fe = n_fe_a; s_bk = n_bk_a;
    bit_out(0, 1'b0);
    b = 8'h41;
    for (int i = 0; i < 8; i++) bit_out(0, b[i]);
    for (int i = 0; i < 3; i++) bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    exp_a.push_back(8'h41);
    check("frm_fe", n_fe_a - s_fe, 1);
    check("frm_bk", n_bk_a - s_bk, 0);
    send_frame(0, 8'h42, 0, 1'b0, 1'b1);
    exp_a.push_back(8'h42);
    tick(4);
    check_stream("frm", 0);

    // Break: line low for 12 bit times.
    s_fe = n_fe_a; s_bk = n_bk_a;
    for (int i = 0; i < 12; i++) bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    check("brk_bk", n_bk_a - s_bk, 1);
    check("brk_fe", n_fe_a - s_fe, 0);
    check("brk_level", lvl_a, 0);
    check_stream("brk", 0);

    // Overrun with the reader stalled.
    rdy_a = 1'b0;
    s_ov = n_ov_a;
    for (int i = 1; i <= 8; i++)
      send_frame(0, 8'(i), 0, 1'b0, 1'b1);
    tick(4);
    check("ovr_pre", n_ov_a - s_ov, 0);
    check("ovr_full", lvl_a, 8);
    check("ovr_stable", rd_data_a, 8'h01);
    send_frame(0, 8'h09, 0, 1'b0, 1'b1);
    tick(4);
    check("ovr_pulse", n_ov_a - s_ov, 1);
    check("ovr_level", lvl_a, 8);
    rdy_a = 1'b1;
    for (int i = 1; i <= 8; i++) exp_a.push_back(8'(i));
    tick(20);
    check_stream("ovr_drain", 0);
    check("ovr_empty", lvl_a, 0);

    // Short glitch on idle line is rejected.
    s_fe = n_fe_a; s_bk = n_bk_a;
    rx_a = 1'b0;
    tick(3);
    rx_a = 1'b1;
    tick(3 * CPB);
    check("glitch_level", lvl_a, 0);
    check_stream("glitch", 0);
    check("glitch_err", (n_fe_a - s_fe) + (n_bk_a - s_bk), 0);

    // Reset in the middle of a data bit.
    rdy_a = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b0);
    rx_a = 1'b1;
    tick(CPB / 2);
    HRESET = 1'b1;
    tick(2);
    HRESET = 1'b0;
    tick(1);
    check("mrst_valid", rd_valid_a, 0);
    check("mrst_level", lvl_a, 0);
    tick(2 * CPB);
    rdy_a = 1'b1;
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
    exp_a.push_back(8'hC3);
    tick(6);
    check_stream("mrst", 0);

    // Random bytes with random idle gaps (including none).
    s_fe = n_fe_a; s_bk = n_bk_a; s_ov = n_ov_a;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 2)) bit_out(0, 1'b1);
      send_frame(0, b, 0, 1'b0, 1'b1);
      exp_a.push_back(b);
    end
    tick(6);
    check_stream("rand", 0);
    check("rand_err",
          (n_fe_a - s_fe) + (n_bk_a - s_bk) + (n_ov_a - s_ov), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
